// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: shifts a WIDTH-bit word out MSB first on x, DIV cycles per bit,
// followed by GAP zero bits; valid/ready intake, done pulse at the end of each word.
// Ports: clk, clr_n (async low), data/valid in, ready/x/busy/done out (all registered).
// Build option: SERIAL_PATTERN_TX_REPEAT_EN re-sends the last accepted word continuously.
module serial_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             ready,
    output logic             x,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t           state;
    logic [WIDTH-2:0] sreg;
    logic [BW-1:0]    bitcnt;
    logic [DW-1:0]    divcnt;
    logic [GW-1:0]    gapcnt;
    logic             start;
    logic [WIDTH-1:0] word;

`ifdef SERIAL_PATTERN_TX_REPEAT_EN
    logic [WIDTH-1:0] hold;
    logic             held;

    // A fresh word always wins over the held one.
    assign start = valid | held;
    assign word  = valid ? data : hold;
`else
    assign start = valid;
    assign word  = data;
`endif

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state  <= ST_IDLE;
            sreg   <= '0;
            bitcnt <= '0;
            divcnt <= '0;
            gapcnt <= '0;
            x      <= 1'b0;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
            hold   <= '0;
            held   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        sreg   <= word[WIDTH-2:0];
                        x      <= word[WIDTH-1];
                        bitcnt <= BIT_LAST;
                        divcnt <= DIV_LAST;
                        state  <= ST_SHIFT;
                        ready  <= 1'b0;
                        busy   <= 1'b1;
                    end
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
                    if (valid) begin
                        hold <= data;
                        held <= 1'b1;
                    end
`endif
                end
                ST_SHIFT: begin
                    if (divcnt != '0) begin
                        divcnt <= divcnt - 1'b1;
                    end else if (bitcnt != '0) begin
                        divcnt <= DIV_LAST;
                        bitcnt <= bitcnt - 1'b1;
                        x      <= sreg[WIDTH-2];
                        sreg   <= sreg << 1;
                    end else begin
                        x <= 1'b0;
                        if (GAP > 0) begin
                            state  <= ST_GAP;
                            divcnt <= DIV_LAST;
                            gapcnt <= GAP_LAST;
                        end else begin
                            state <= ST_IDLE;
                            ready <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (divcnt != '0) begin
                        divcnt <= divcnt - 1'b1;
                    end else if (gapcnt != '0) begin
                        gapcnt <= gapcnt - 1'b1;
                        divcnt <= DIV_LAST;
                    end else begin
                        state <= ST_IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    x     <= 1'b0;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
